// File: rtl/instr_fetch_if.sv
// Memory read port of the fetch stage: one outstanding request, grant handshake and a
// single response pulse per accepted request.
interface instr_fetch_if;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_gnt, mem_rvalid, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: fetch PC, one-outstanding memory read FSM and an instruction FIFO toward the decoder.
// Define FETCH_PARITY_EN to check odd parity of returned words and freeze fetch on an error.
module instr_fetch #(
  parameter logic [11:0] RESET_PC   = 12'o4000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic          clock,
  input  logic          rst,
  instr_fetch_if.master mem,
  output logic          instr_valid,
  output logic [14:0]   instr,
  output logic [11:0]   pc,
  input  logic          dec_ready,
  input  logic          redirect,
  input  logic [11:0]   redirect_pc,
  input  logic          halt,
  output logic          parity_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
  state_t state, state_next;

  logic [11:0]   fetch_pc, req_addr;
  logic [14:0]   fifo_instr [FIFO_DEPTH];
  logic [11:0]   fifo_pc    [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          stall, parity_bad, grant, push, pop;

`ifdef FETCH_PARITY_EN
  assign parity_bad = ~^mem.mem_rdata;

  always_ff @(posedge clock) begin
    if (rst) parity_err <= 1'b0;
    else if (state == WAIT && mem.mem_rvalid && !redirect && parity_bad) parity_err <= 1'b1;
  end
`else
  logic unused_parity_bit;
  assign unused_parity_bit = mem.mem_rdata[15];
  assign parity_bad        = 1'b0;
  assign parity_err        = 1'b0;
`endif

  // A parity error freezes fetch exactly like a permanent halt.
  assign stall = halt | parity_err;

  always_ff @(posedge clock) begin
    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:  if (!stall && (redirect || count < DEPTH_C)) state_next = REQ;
      REQ: begin
        if (mem.mem_gnt)            state_next = redirect ? DRAIN : WAIT;
        else if (redirect && stall) state_next = IDLE;
      end
      WAIT: begin
        if (mem.mem_rvalid) begin
          if (redirect)
            state_next = stall ? IDLE : REQ;
          else if (!stall && !parity_bad && (count + CW'(1)) < DEPTH_C)
            state_next = REQ;
          else
            state_next = IDLE;
        end else if (redirect) begin
          state_next = DRAIN;
        end
      end
      DRAIN: if (mem.mem_rvalid) state_next = stall ? IDLE : REQ;
      default: state_next = IDLE;
    endcase
  end

  assign mem.mem_req  = (state == REQ);
  assign mem.mem_addr = fetch_pc;

  always_comb begin
    grant       = (state == REQ) && mem.mem_gnt;
    push        = (state == WAIT) && mem.mem_rvalid && !redirect && !parity_bad;
    instr_valid = (count != '0);
    pop         = instr_valid && dec_ready && !redirect;
    instr       = instr_valid ? fifo_instr[rd_ptr] : '0;
    pc          = instr_valid ? fifo_pc[rd_ptr]    : '0;
  end

  // Redirect outranks grant and FIFO traffic; a same-edge push or pop is dropped by the flush.
  always_ff @(posedge clock) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (redirect)   fetch_pc <= redirect_pc;
      else if (grant) fetch_pc <= fetch_pc + 12'd1;
      if (grant) req_addr <= fetch_pc;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // NOTE: storage is not reset; instr/pc are masked by instr_valid so stale entries never show.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_instr[wr_ptr] <= mem.mem_rdata[14:0];
      fifo_pc[wr_ptr]    <= req_addr;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios, then randomized traffic checked
// against a stream-level model of the fetched address sequence.
module tb_instr_fetch;
  localparam logic [11:0] RESET_PC = 12'o4000;
  localparam int          DEPTH    = 2;

  logic        clock = 1'b0;
  logic        rst, dec_ready, redirect, halt;
  logic [11:0] redirect_pc;
  logic        instr_valid, parity_err;
  logic [14:0] instr;
  logic [11:0] pc;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .rst(rst), .mem(bus),
    .instr_valid(instr_valid), .instr(instr), .pc(pc), .dec_ready(dec_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .parity_err(parity_err)
  );

  always #5 clock = ~clock;

  int n_compared = 0, n_mismatched = 0;
  int cyc = 0, n_grants = 0, n_pops = 0, n_resp = 0;
  int gnt_pct = 100, lat_min = 1, lat_max = 1, corrupt_idx = -1;

  always @(posedge clock) cyc++;

  function automatic logic [14:0] instr_of(input logic [11:0] a);
    return {a[2:0], a ^ 12'hA5C};
  endfunction

  function automatic logic [15:0] word_of(input logic [11:0] a);
    logic [14:0] w;
    w = instr_of(a);
    return {~^w, w};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Memory: grants with probability gnt_pct, answers after lat_min..lat_max cycles, drops on reset.
  initial begin
    logic        pending;
    int          lat_left;
    logic [11:0] pend_addr;
    pending = 1'b0;
    lat_left = 0;
    pend_addr = '0;
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clock);
      #2;
      bus.mem_gnt = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata = '0;
      if (rst) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          lat_left--;
          if (lat_left == 0) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata = (n_resp == corrupt_idx) ? 16'h0000 : word_of(pend_addr);
            n_resp++;
            pending = 1'b0;
          end
        end
        if (bus.mem_req && !pending && ($urandom_range(99) < gnt_pct)) begin
          bus.mem_gnt = 1'b1;
          pending = 1'b1;
          pend_addr = bus.mem_addr;
          lat_left = $urandom_range(lat_max, lat_min);
        end
      end
    end
  end

  // Stream model: grants walk consecutive addresses from the last redirect/reset, the decoder
  // sees exactly that sequence, and granted-but-unconsumed words never exceed the FIFO depth.
  logic [11:0] exp_pc = RESET_PC, exp_fetch = RESET_PC, hold_pc = '0;
  logic [14:0] hold_instr = '0;
  logic        after_redirect = 1'b0, hold = 1'b0;
  int          inflight = 0;

  always @(negedge clock) begin
    if (rst) begin
      exp_pc = RESET_PC;
      exp_fetch = RESET_PC;
      inflight = 0;
      after_redirect = 1'b0;
      hold = 1'b0;
    end else begin
      if (after_redirect) check("sb_flush_valid", 32'(instr_valid), 32'd0);
      if (hold) begin
        check("sb_hold_pc", 32'(pc), 32'(hold_pc));
        check("sb_hold_instr", 32'(instr), 32'(hold_instr));
      end
      if (bus.mem_req && bus.mem_gnt) begin
        n_grants++;
        check("sb_grant_addr", 32'(bus.mem_addr), 32'(exp_fetch));
        check("sb_slot_bound", 32'(inflight < DEPTH), 32'd1);
        if (!redirect) begin
          exp_fetch++;
          inflight++;
        end
      end
      if (instr_valid && dec_ready && !redirect) begin
        n_pops++;
        check("sb_pop_pc", 32'(pc), 32'(exp_pc));
        check("sb_pop_instr", 32'(instr), 32'(instr_of(exp_pc)));
        exp_pc++;
        inflight--;
      end
      if (redirect) begin
        exp_fetch = redirect_pc;
        exp_pc = redirect_pc;
        inflight = 0;
      end
      after_redirect = redirect;
      hold = instr_valid && !dec_ready && !redirect;
      hold_pc = pc;
      hold_instr = instr;
    end
  end

  task automatic wait_grant(input string tag, input int max_cyc, output logic [11:0] addr);
    logic found;
    found = 1'b0;
    addr = '0;
    for (int i = 0; i < max_cyc && !found; i++) begin
      @(negedge clock);
      if (bus.mem_req && bus.mem_gnt) begin
        found = 1'b1;
        addr = bus.mem_addr;
      end
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int max_cyc, output logic [11:0] addr);
    logic found;
    found = 1'b0;
    addr = '0;
    for (int i = 0; i < max_cyc && !found; i++) begin
      @(negedge clock);
      if (instr_valid) begin
        found = 1'b1;
        addr = pc;
      end
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req"},   32'(bus.mem_req),  32'd0);
    check({tag, "_addr"},  32'(bus.mem_addr), 32'(RESET_PC));
    check({tag, "_valid"}, 32'(instr_valid),  32'd0);
    check({tag, "_instr"}, 32'(instr),        32'd0);
    check({tag, "_pc"},    32'(pc),           32'd0);
    check({tag, "_perr"},  32'(parity_err),   32'd0);
  endtask

  initial begin
    logic [11:0] g, a;
    logic [11:0] pops [$];
    int g_cyc, v_cyc, n_req, base;

    rst = 1'b1; dec_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    step();
    @(negedge clock);
    check_reset_state("reset");
    step(); rst = 1'b0;

    // Cold start with latency 1, decoder stalled.
    wait_grant("first_grant", 20, g);
    g_cyc = cyc;
    check("first_grant_addr", 32'(g), 32'(RESET_PC));
    wait_valid("first_valid", 20, a);
    v_cyc = cyc;
    check("first_valid_latency", 32'(v_cyc - g_cyc), 32'd2);
    check("first_valid_pc", 32'(a), 32'(RESET_PC));

    repeat (10) @(negedge clock);
    check("full_grants", 32'(n_grants), 32'd2);
    n_req = 0;
    repeat (5) begin
      @(negedge clock);
      n_req += int'(bus.mem_req);
    end
    check("full_no_req", 32'(n_req), 32'd0);
    check("full_head_pc", 32'(pc), 32'(RESET_PC));
    check("full_head_instr", 32'(instr), 32'(instr_of(RESET_PC)));

    step(); dec_ready = 1'b1;
    @(negedge clock);
    check("drain0_valid", 32'(instr_valid), 32'd1);
    check("drain0_pc", 32'(pc), 32'(RESET_PC));
    @(negedge clock);
    check("drain1_valid", 32'(instr_valid), 32'd1);
    check("drain1_pc", 32'(pc), 32'(RESET_PC + 12'd1));

    // Redirect while a latency-3 response is in flight.
    lat_min = 3; lat_max = 3;
    wait_grant("redir_grant", 20, g);
    step(); redirect = 1'b1; redirect_pc = 12'o2000;
    step(); redirect = 1'b0;
    wait_valid("redir_valid", 30, a);
    check("redir_first_pc", 32'(a), 32'(12'o2000));

    // PC wrap from 7777 to 0000.
    lat_min = 1; lat_max = 1;
    step(); redirect = 1'b1; redirect_pc = 12'o7777;
    step(); redirect = 1'b0;
    for (int i = 0; i < 40 && pops.size() < 2; i++) begin
      @(negedge clock);
      if (instr_valid && dec_ready) pops.push_back(pc);
    end
    check("wrap_count", 32'(pops.size()), 32'd2);
    if (pops.size() == 2) begin
      check("wrap_pc0", 32'(pops[0]), 32'(12'o7777));
      check("wrap_pc1", 32'(pops[1]), 32'(12'o0000));
    end

    // Halt while waiting: the pending word lands, nothing new is requested.
    lat_min = 2; lat_max = 2;
    wait_grant("halt_grant", 20, g);
    step(); halt = 1'b1;
    n_req = 0;
    a = ~g;
    repeat (15) begin
      @(negedge clock);
      n_req += int'(bus.mem_req);
      if (instr_valid && dec_ready) a = pc;
    end
    check("halt_no_req", 32'(n_req), 32'd0);
    check("halt_last_word", 32'(a), 32'(g));
    check("halt_empty", 32'(instr_valid), 32'd0);
    step(); halt = 1'b0;
    wait_grant("resume_grant", 10, a);
    check("resume_addr", 32'(a), 32'(g + 12'd1));

    // Randomized traffic: grant gaps, latencies, back-pressure, halts and redirects.
    gnt_pct = 70; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      step();
      dec_ready = ($urandom_range(3) != 0);
      redirect = ($urandom_range(39) == 0);
      redirect_pc = 12'($urandom);
      if ($urandom_range(59) == 0) halt = ~halt;
    end
    step(); redirect = 1'b0; halt = 1'b0; dec_ready = 1'b1;
    base = n_pops;
    repeat (40) @(negedge clock);
    check("rand_liveness", 32'((n_pops - base) >= 4), 32'd1);

    // Reset with a response in flight: it is dropped and fetch restarts at RESET_PC.
    gnt_pct = 100; lat_min = 3; lat_max = 3;
    wait_grant("rst_grant", 20, g);
    step(); rst = 1'b1;
    step();
    @(negedge clock);
    check_reset_state("midrst");
    step(); rst = 1'b0;
    wait_valid("post_rst_valid", 20, a);
    check("post_rst_pc", 32'(a), 32'(RESET_PC));

`ifdef FETCH_PARITY_EN
    lat_min = 1; lat_max = 1;
    corrupt_idx = n_resp;
    a = '0;
    for (int i = 0; i < 20 && !parity_err; i++) @(negedge clock);
    check("parity_flag", 32'(parity_err), 32'd1);
    n_req = 0;
    repeat (20) begin
      @(negedge clock);
      n_req += int'(bus.mem_req);
    end
    check("parity_no_req", 32'(n_req), 32'd0);
    check("parity_sticky", 32'(parity_err), 32'd1);
    check("parity_no_push", 32'(instr_valid), 32'd0);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clock);
    check("parity_cleared", 32'(parity_err), 32'd0);
`else
    check("parity_tied", 32'(parity_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
